// File: rtl/l1tlb_refill_ctrl.sv
// L1 TLB miss refill controller: one outstanding page walk, round-robin victim fill,
// page-fault reporting, and sfence handling that drains any already-accepted walk.
package l1tlb_pkg;
    typedef struct packed {
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d, a, g, u, x, w, r, v;
    } PTEEntry;
endpackage

module l1tlb_refill_ctrl
    import l1tlb_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int VADDR_SIZE = 39,
    parameter int TLB_OFFSET = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_miss_valid,
    input  logic [VADDR_SIZE-1:0] i_miss_vaddr,
    input  logic                  i_flush,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [VADDR_SIZE-1:0] o_req_vaddr,
    input  logic                  i_resp_valid,
    input  logic [VADDR_SIZE-1:0] i_resp_vaddr,
    input  logic                  i_resp_exception,
    input  PTEEntry               i_resp_entry,
    input  logic [1:0]            i_resp_wpn,
    output logic                  o_tlb_we,
    output logic [ADDR_WIDTH-1:0] o_tlb_widx,
    output PTEEntry               o_tlb_wentry,
    output logic [1:0]            o_tlb_wpn,
    output logic [VADDR_SIZE-1:0] o_tlb_waddr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault,
    output logic [VADDR_SIZE-1:0] o_fault_vaddr
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_WB} state_t;

    state_t                r_state, w_state_nxt;
    logic [VADDR_SIZE-1:0] r_vaddr;
    PTEEntry               r_entry;
    logic [1:0]            r_wpn;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_fault;
    logic [VADDR_SIZE-1:0] r_fault_vaddr;

    logic w_match, w_capture, w_fill, w_fault_set;
    logic w_unused;

    // Only the VPN identifies the walk; page-offset bits of the response are don't-care.
    assign w_match  = i_resp_valid &&
                      (i_resp_vaddr[VADDR_SIZE-1:TLB_OFFSET] == r_vaddr[VADDR_SIZE-1:TLB_OFFSET]);
    assign w_unused = ^i_resp_vaddr[TLB_OFFSET-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_fill      = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            S_IDLE: if (i_miss_valid && !i_flush) begin
                w_state_nxt = S_REQ;
                w_capture   = 1'b1;
            end
            S_REQ: begin
                // A flush racing an accepted request must still swallow its response.
                if (i_flush)          w_state_nxt = i_req_ready ? S_DRAIN : S_IDLE;
                else if (i_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_state_nxt = w_match ? S_IDLE : S_DRAIN;
                end else if (w_match) begin
                    w_state_nxt = i_resp_exception ? S_IDLE : S_WB;
                    w_fill      = !i_resp_exception;
                    w_fault_set = i_resp_exception;
                end
            end
            S_DRAIN: if (w_match) w_state_nxt = S_IDLE;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vaddr       <= '0;
            r_entry       <= '0;
            r_wpn         <= '0;
            r_ptr         <= '0;
            r_fault       <= 1'b0;
            r_fault_vaddr <= '0;
        end else begin
            r_fault <= w_fault_set;
            if (w_capture)   r_vaddr       <= i_miss_vaddr;
            if (w_fault_set) r_fault_vaddr <= r_vaddr;
            if (w_fill) begin
                r_entry <= i_resp_entry;
                r_wpn   <= i_resp_wpn;
            end
            if (r_state == S_WB)
                r_ptr <= (r_ptr == ADDR_WIDTH'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_req_valid   = (r_state == S_REQ);
    assign o_req_vaddr   = r_vaddr;
    assign o_tlb_we      = (r_state == S_WB);
    assign o_tlb_widx    = r_ptr;
    assign o_tlb_wentry  = r_entry;
    assign o_tlb_wpn     = r_wpn;
    assign o_tlb_waddr   = r_vaddr;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_WB) || r_fault;
    assign o_fault       = r_fault;
    assign o_fault_vaddr = r_fault_vaddr;
endmodule

// File: doc/l1tlb_refill_ctrl.md
# l1tlb_refill_ctrl

Miss-handling stage for a single-port L1 TLB. It captures a miss, issues one page-walk request to the PTW/L2 TLB with a valid/ready handshake, and waits for the response. On success it writes the result into the L1 TLB through that TLB's write port (`we`/`widx`/`wentry`/`wpn`/`waddr`), choosing the victim slot round-robin; on a page fault it raises an exception pulse instead. It handles one miss at a time, and the requester stalls on `busy`.

## Interface
- `DEPTH`, 16, number of L1 TLB entries.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, victim index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `miss_valid`  in  1  L1 TLB miss pulse.
- `miss_vaddr`  in  `VADDR_SIZE`  virtual address of the missing access, valid with `miss_valid`.
- `flush`  in  1  sfence; cancels any in-flight miss.
- `req_valid`  out  1  page-walk request valid.
- `req_ready`  in  1  PTW accepts the request.
- `req_vaddr`  out  `VADDR_SIZE`  captured miss address.
- `resp_valid`  in  1  PTW response.
- `resp_vaddr`  in  `VADDR_SIZE`  address the response belongs to.
- `resp_exception`  in  1  walk produced a page fault.
- `resp_entry`  in  PTEEntry  leaf PTE.
- `resp_wpn`  in  2  leaf level (0 = 4K, 1 = mega, 2 = giga).
- `tlb_we`  out  1  L1 TLB write strobe.
- `tlb_widx`  out  `ADDR_WIDTH`  victim slot.
- `tlb_wentry`  out  PTEEntry  entry to write.
- `tlb_wpn`  out  2  page size.
- `tlb_waddr`  out  `VADDR_SIZE`  vaddr tag source.
- `busy`  out  1  miss outstanding; requester holds off new misses and replays.
- `done`  out  1  one-cycle pulse when the miss resolves (fill or fault); requester replays.
- `fault`  out  1  one-cycle page-fault pulse, coincident with `done`.
- `fault_vaddr`  out  `VADDR_SIZE`  faulting address, valid with `fault`.

## Operation
- **States:** IDLE, REQ, WAIT, DRAIN, WB.
- **IDLE:**
  - `miss_valid & ~flush` → capture `miss_vaddr` → REQ.
  - `miss_valid` is ignored in every other state.
- **REQ:**
  - `req_valid` = 1.
  - `req_vaddr` = captured address, held stable until accepted.
  - `req_ready` → WAIT.
  - `flush` → IDLE. If `req_ready` is also high that cycle, go to DRAIN instead, because the request was accepted.
- **WAIT:** a response is accepted only if `resp_valid` and `resp_vaddr[VADDR_SIZE-1:TLB_OFFSET]` equals the captured VPN; mismatching responses are ignored.
  - Accepted, `resp_exception` = 0 → latch `resp_entry`/`resp_wpn` → WB.
  - Accepted, `resp_exception` = 1 → `fault`, `done`, `fault_vaddr` registered → IDLE. No write.
  - `flush` without an accepted response → DRAIN.
  - `flush` together with an accepted response → response discarded; no write, no fault, no `done` → IDLE.
- **DRAIN:** wait for the matching response and discard it, then → IDLE. `busy` stays 1.
- **WB:**
  - Drive `tlb_we` = 1 and `done` = 1 for exactly one cycle.
  - `tlb_widx` = round-robin pointer, `tlb_waddr` = captured vaddr, `tlb_wentry`/`tlb_wpn` = latched response.
  - → IDLE.
  - `flush` in WB is ignored; the write completes.
- **Round-robin pointer:** `ADDR_WIDTH` bits, reset 0. Increments by 1 after each WB and wraps from `DEPTH-1` to 0. It does not change on faults or flushes.
- **`busy`** = (state != IDLE).
- **Reset:**
  - State IDLE, pointer 0.
  - Outputs `req_valid`, `tlb_we`, `done`, `fault`, `busy` = 0.
  - All address/data outputs = 0.
  - Asserting reset mid-operation abandons the miss; a PTW response arriving after reset release is ignored in IDLE.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `miss_valid` in cycle T → `req_valid` = 1 in T+1.
- Handshake completes in the cycle where `req_valid & req_ready` → state WAIT from the next cycle.
- Matching `resp_valid` in cycle R:
  - Success: `tlb_we`/`done` in R+1, `busy` = 0 in R+2.
  - Fault: `fault`/`done` in R+1, `busy` = 0 in R+1.
- Minimum turnaround (`req_ready` = 1 immediately, response one cycle later): miss at T, `tlb_we` at T+3.
- A new miss is accepted the first cycle `busy` = 0.

## Test plan
- **Basic fill:**
  - Stimulus: miss `vaddr=0x12345678`; `req_ready` high at T+1; response at T+3 with `wpn=0`.
  - Required: `req_vaddr=0x12345678`; `tlb_we` at T+4 with `widx=0`, `waddr=0x12345678`; `busy` low at T+5.
- **Backpressure:**
  - Stimulus: `req_ready` held low for 5 cycles.
  - Required: `req_valid` stays 1 and `req_vaddr` stays stable throughout; exactly one handshake occurs.
- **Fault:**
  - Stimulus: response with `resp_exception=1`.
  - Required: `fault`=`done`=1 for one cycle, `fault_vaddr` equals the miss address, `tlb_we` never asserts, pointer unchanged.
- **Wrap:**
  - Stimulus: 17 successive successful fills with `DEPTH=16`.
  - Required: `widx` sequence 0..15 then 0.
- **Flush in WAIT:**
  - Stimulus: flush while waiting; matching response arrives 3 cycles later.
  - Required: `busy` stays 1 until that response; no `tlb_we`, no `done`; a subsequent miss proceeds normally.
- **Mismatch and reset:**
  - Stimulus: response with a different VPN in WAIT; separately, `rst` asserted during REQ.
  - Required: the mismatching response is ignored (still WAIT); after reset all outputs are 0, state IDLE, pointer 0.
